ram_cmd_arbiter: RTL

- Sequences the single-port, command-coded SPI RAM on behalf of two independent requesters.
- Turns each requester's word-level read or write into the RAM's two-command sequences on a 10-bit command bus:
  - opcode 00: set write address
  - opcode 01: write data
  - opcode 10: set read address
  - opcode 11: read strobe
- Arbitrates round-robin and watches the RAM's tx_valid with a timeout.
- Sits between the SPI-slave side and the RAM, replacing direct slave-to-RAM wiring when a second master (for example, a BIST or debug port) shares the memory.

---
 rtl/ram_cmd_arbiter_if.sv | 27 ++
 rtl/ram_cmd_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter_if.sv
// Requester and RAM command-bus signals of the two-master SPI RAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface ram_cmd_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output gnt, done, rdata, err, busy, ram_din, ram_rx_valid
  );

  modport master (
    output req, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  gnt, done, rdata, err, busy, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that turns two requesters' word reads/writes into the
// command-coded RAM's two-command sequences, with a read-data timeout.
module ram_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 4
) (
  input logic              clk,
  input logic              rst_n,
  ram_cmd_arbiter_if.slave bus
);

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdCmd,
    StRdWait,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic [9:0] ram_din_q, ram_din_d;
  logic       ram_rx_valid_q, ram_rx_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      owner_q        <= 1'b0;
      last_owner_q   <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      cnt_q          <= 4'h0;
      err_q          <= 1'b0;
      rdata_q        <= 8'h00;
      ram_din_q      <= 10'h000;
      ram_rx_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          // On contention the requester that did not go last wins.
          owner_d      = (bus.req == 2'b11) ? ~last_owner_q : bus.req[1];
          last_owner_d = owner_d;
          we_d         = bus.req_we[owner_d];
          addr_d       = owner_d ? bus.req_addr[15:8] : bus.req_addr[7:0];
          wdata_d      = owner_d ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
          err_d        = 1'b0;
          state_d      = we_d ? StWrAddr : StRdAddr;
        end
      end
      StWrAddr: state_d = StWrData;
      StWrData: state_d = StDone;
      StRdAddr: state_d = StRdCmd;
      StRdCmd:  state_d = StRdWait;
      StRdWait: begin
        if (bus.ram_tx_valid) begin
          rdata_d = bus.ram_dout;
          cnt_d   = 4'h0;
          state_d = StDone;
        end else if (cnt_q + 4'd1 == TimeoutCnt) begin
          cnt_d   = 4'h0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Commands are decoded from the next state so the registered bus lines up
  // with the cycle in which that state is active.
  always_comb begin
    ram_din_d      = 10'h000;
    ram_rx_valid_d = 1'b0;
    unique case (state_d)
      StWrAddr: begin
        ram_din_d      = {2'b00, addr_d};
        ram_rx_valid_d = 1'b1;
      end
      StWrData: begin
        ram_din_d      = {2'b01, wdata_d};
        ram_rx_valid_d = 1'b1;
      end
      StRdAddr: begin
        ram_din_d      = {2'b10, addr_d};
        ram_rx_valid_d = 1'b1;
      end
      StRdCmd: begin
        ram_din_d      = {2'b11, 8'h00};
        ram_rx_valid_d = 1'b1;
      end
      default: begin
        ram_din_d      = 10'h000;
        ram_rx_valid_d = 1'b0;
      end
    endcase
  end

  logic [1:0] owner_onehot;
  assign owner_onehot     = {owner_q, ~owner_q};

  assign bus.busy         = (state_q != StIdle);
  assign bus.gnt          = bus.busy ? owner_onehot : 2'b00;
  assign bus.done         = (state_q == StDone) ? owner_onehot : 2'b00;
  assign bus.err          = (state_q == StDone) && err_q;
  assign bus.rdata        = rdata_q;
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_rx_valid = ram_rx_valid_q;

endmodule
